cpu_core: RTL and testbench



---
 rtl/cpu_core.sv | 167 ++++++++++++++++
 tb/tb_cpu_core.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core.sv
// cpu_core: minimal multi-cycle 32-bit load/store CPU.
// Program and data share one internal word-addressed RAM (instance ram, array memory).
// Instruction word: [31:28] op, [27:24] rd, [23:20] rn, [19:16] rm, [15:0] imm.

// Unified RAM: combinational read, synchronous write, never cleared by reset.
module cpu_ram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] memory [MEM_DEPTH];

  // Write port; contents survive reset so a preloaded program is kept.
  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];
endmodule

module cpu_core #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int NUM_REGS  = 16
) (
  input logic clk,
  input logic rst
);
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVI = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_ORR  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_B    = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC  = 3'd1,
    MEM   = 3'd2,
    WB    = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, ea, mem_addr;
  logic [DATA_W-1:0] ir, result, mdr;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              halted;

  logic [3:0]        op, rd, rn, rm;
  logic [DATA_W-1:0] imm_ext, rn_val, rm_val, rd_val, alu_out, wb_data, mem_rdata;
  logic              mem_we;

  assign op      = ir[31:28];
  assign rd      = ir[27:24];
  assign rn      = ir[23:20];
  assign rm      = ir[19:16];
  assign imm_ext = {{(DATA_W-16){ir[15]}}, ir[15:0]};
  assign rn_val  = regs[rn];
  assign rm_val  = regs[rm];
  assign rd_val  = regs[rd];

  // One RAM port: instruction fetch uses pc, MEM state uses the latched effective address.
  assign mem_addr = (state == FETCH) ? pc : ea;
  // A reset arriving during MEM aborts the store as well.
  assign mem_we   = (state == MEM) && (op == OP_STR) && !rst;
  assign wb_data  = (op == OP_LDR) ? mdr : result;

  cpu_ram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) ram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (rd_val),
    .rdata (mem_rdata)
  );

  // ALU: modular arithmetic, no flags; MOVI passes the sign-extended immediate.
  always_comb begin
    alu_out = imm_ext;
    case (op)
      OP_ADD:  alu_out = rn_val + rm_val;
      OP_SUB:  alu_out = rn_val - rm_val;
      OP_AND:  alu_out = rn_val & rm_val;
      OP_ORR:  alu_out = rn_val | rm_val;
      default: alu_out = imm_ext;
    endcase
  end

  // Next-state decode; unknown opcodes behave as NOP.
  always_comb begin
    state_next = state;
    case (state)
      FETCH: state_next = EXEC;
      EXEC: begin
        case (op)
          OP_NOP:                              state_next = FETCH;
          OP_MOVI, OP_ADD, OP_SUB, OP_AND, OP_ORR: state_next = WB;
          OP_LDR, OP_STR:                      state_next = MEM;
          OP_HALT:                             state_next = HALT;
          default:                             state_next = FETCH;
        endcase
      end
      MEM:     state_next = (op == OP_LDR) ? WB : FETCH;
      WB:      state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // State register plus pc/ir/result/ea/mdr datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      result <= '0;
      mdr    <= '0;
      ea     <= '0;
      halted <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        FETCH: begin
          ir <= mem_rdata;
          pc <= pc + ADDR_W'(1);
        end
        EXEC: begin
          result <= alu_out;
          // Effective address wraps to ADDR_W bits, so only the low bits are summed.
          ea     <= rn_val[ADDR_W-1:0] + imm_ext[ADDR_W-1:0];
          // pc already points past this instruction, so branches are relative to it.
          if (op == OP_B || (op == OP_BEQ && rn_val == rm_val))
            pc <= pc + imm_ext[ADDR_W-1:0];
          if (op == OP_HALT) halted <= 1'b1;
        end
        MEM: begin
          if (op == OP_LDR) mdr <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Register file: all registers writable, written only in WB.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) regs[i] <= '0;
      else if (state == WB && rd == 4'(i)) regs[i] <= wb_data;
    end
  end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: table-driven program vectors plus hand-written reset/halt/wrap sequences.
module tb_cpu_core;
  logic clk;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_core dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [7:0][31:0] prog;
    int               daddr;
    logic [31:0]      dval;
    int               cycles;
    int               pc;
    int               ra;
    logic [31:0]      va;
    int               rb;
    logic [31:0]      vb;
    int               maddr;
    logic [31:0]      mval;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rn, input logic [3:0] rm,
                                      input logic [15:0] imm);
    return {op, rd, rn, rm, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Clear RAM and load a table vector (call only while rst is high).
  task automatic preload_vec(input int vi);
    for (int k = 0; k < 256; k++) dut.ram.memory[k] <= 32'h0;
    for (int k = 0; k < 8; k++) dut.ram.memory[k] <= vecs[vi].prog[k];
    if (vecs[vi].daddr >= 0) dut.ram.memory[vecs[vi].daddr] <= vecs[vi].dval;
  endtask

  task automatic reset_with_vec(input int vi);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    preload_vec(vi);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Count rising edges until halted, bounded by budget.
  task automatic run_until_halt(input int budget, output int cycles);
    cycles = 0;
    while (!dut.halted && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int waited;
    rst = 1'b1;

    // name, prog, daddr, dval, cycles, pc, ra, va, rb, vb, maddr, mval
    vecs[0] = '{"ldr", '0, 20, 32'hDEADBEEF, 9, 3, 1, 32'd16, 2, 32'hDEADBEEF, 20, 32'hDEADBEEF};
    vecs[0].prog[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'd16);
    vecs[0].prog[1] = enc(4'h6, 4'd2, 4'd1, 4'd0, 16'd4);
    vecs[0].prog[2] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);

    vecs[1] = '{"alu_add_sub", '0, -1, 32'h0, 14, 5, 3, 32'd2, 4, 32'hFFFFFFF8, 0, 32'h0};
    vecs[1].prog[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'd5);
    vecs[1].prog[1] = enc(4'h1, 4'd2, 4'd0, 4'd0, 16'hFFFD);
    vecs[1].prog[2] = enc(4'h2, 4'd3, 4'd1, 4'd2, 16'd0);
    vecs[1].prog[3] = enc(4'h3, 4'd4, 4'd2, 4'd1, 16'd0);
    vecs[1].prog[4] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    vecs[1].mval    = vecs[1].prog[0];

    vecs[2] = '{"str_ldr", '0, -1, 32'h0, 12, 4, 1, 32'h77, 5, 32'h77, 100, 32'h77};
    vecs[2].prog[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h0077);
    vecs[2].prog[1] = enc(4'h7, 4'd1, 4'd0, 4'd0, 16'd100);
    vecs[2].prog[2] = enc(4'h6, 4'd5, 4'd0, 4'd0, 16'd100);
    vecs[2].prog[3] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);

    vecs[3] = '{"branch", '0, -1, 32'h0, 9, 5, 1, 32'd1, 2, 32'd0, 3, 32'h0};
    vecs[3].prog[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'd1);
    vecs[3].prog[1] = enc(4'h9, 4'd0, 4'd1, 4'd0, 16'd1);
    vecs[3].prog[2] = enc(4'h8, 4'd0, 4'd0, 4'd0, 16'd1);
    vecs[3].prog[3] = enc(4'h1, 4'd2, 4'd0, 4'd0, 16'd9);
    vecs[3].prog[4] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    vecs[3].mval    = vecs[3].prog[3];

    vecs[4] = '{"and_orr", '0, -1, 32'h0, 14, 5, 3, 32'h30, 4, 32'hFC, 2, 32'h0};
    vecs[4].prog[0] = enc(4'h1, 4'd1, 4'd0, 4'd0, 16'h00F0);
    vecs[4].prog[1] = enc(4'h1, 4'd2, 4'd0, 4'd0, 16'h003C);
    vecs[4].prog[2] = enc(4'h4, 4'd3, 4'd1, 4'd2, 16'd0);
    vecs[4].prog[3] = enc(4'h5, 4'd4, 4'd1, 4'd2, 16'd0);
    vecs[4].prog[4] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    vecs[4].mval    = vecs[4].prog[2];

    vecs[5] = '{"beq_taken_nop_unknown", '0, -1, 32'h0, 11, 6, 6, 32'd0, 7, 32'hFFFFFFFF, 4, 32'h0};
    vecs[5].prog[0] = enc(4'h0, 4'd0, 4'd0, 4'd0, 16'd0);
    vecs[5].prog[1] = enc(4'h9, 4'd0, 4'd0, 4'd0, 16'd1);
    vecs[5].prog[2] = enc(4'h1, 4'd6, 4'd0, 4'd0, 16'd7);
    vecs[5].prog[3] = enc(4'h1, 4'd7, 4'd0, 4'd0, 16'hFFFF);
    vecs[5].prog[4] = enc(4'hA, 4'd9, 4'd1, 4'd2, 16'd0);
    vecs[5].prog[5] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    vecs[5].mval    = vecs[5].prog[4];

    vecs[6] = '{"self_modify", '0, 20, 32'h1300002A, 14, 5, 3, 32'd42, 1, 32'h1300002A, 3, 32'h1300002A};
    vecs[6].prog[0] = enc(4'h6, 4'd1, 4'd0, 4'd0, 16'd20);
    vecs[6].prog[1] = enc(4'h7, 4'd1, 4'd0, 4'd0, 16'd3);
    vecs[6].prog[2] = enc(4'h0, 4'd0, 4'd0, 4'd0, 16'd0);
    vecs[6].prog[3] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    vecs[6].prog[4] = enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);

    // Table-driven program vectors.
    for (int v = 0; v < 7; v++) begin
      reset_with_vec(v);
      run_until_halt(300, cyc);
      $display("vec %0d %s: cycles=%0d pc=%0d", v, vecs[v].name, cyc, dut.pc);
      chk({vecs[v].name, ".halted"}, {31'b0, dut.halted}, 32'd1);
      chk({vecs[v].name, ".cycles"}, cyc, vecs[v].cycles);
      chk({vecs[v].name, ".pc"}, {24'b0, dut.pc}, vecs[v].pc);
      chk({vecs[v].name, ".reg_a"}, dut.regs[vecs[v].ra], vecs[v].va);
      chk({vecs[v].name, ".reg_b"}, dut.regs[vecs[v].rb], vecs[v].vb);
      chk({vecs[v].name, ".mem"}, dut.ram.memory[vecs[v].maddr], vecs[v].mval);
    end

    // Reset after a run: registers cleared, RAM preserved.
    reset_with_vec(0);
    run_until_halt(300, cyc);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("reset: pc=%0d state=%0d halted=%0d", dut.pc, dut.state, dut.halted);
    chk("reset.pc", {24'b0, dut.pc}, 32'd0);
    chk("reset.state", {29'b0, dut.state}, 32'd0);
    chk("reset.halted", {31'b0, dut.halted}, 32'd0);
    for (int r = 0; r < 16; r++) chk($sformatf("reset.r%0d", r), dut.regs[r], 32'd0);
    for (int k = 0; k < 4; k++) chk($sformatf("reset.ram%0d", k), dut.ram.memory[k], vecs[0].prog[k]);
    rst = 1'b0;

    // Mid-run reset while the LDR sits in MEM: no writeback, program restarts cleanly.
    waited = 0;
    while (dut.state != 3'd2 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("midrst.reached_mem", {29'b0, dut.state}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    $display("midrst: pc=%0d state=%0d r2=%h", dut.pc, dut.state, dut.regs[2]);
    chk("midrst.pc", {24'b0, dut.pc}, 32'd0);
    chk("midrst.state", {29'b0, dut.state}, 32'd0);
    chk("midrst.r2", dut.regs[2], 32'd0);
    rst = 1'b0;
    run_until_halt(300, cyc);
    $display("midrst rerun: cycles=%0d r2=%h", cyc, dut.regs[2]);
    chk("midrst.cycles", cyc, 32'd9);
    chk("midrst.r2_after", dut.regs[2], 32'hDEADBEEF);
    chk("midrst.pc_after", {24'b0, dut.pc}, 32'd3);

    // HALT is terminal: pc and state frozen.
    repeat (5) @(posedge clk);
    #1;
    $display("halt hold: pc=%0d state=%0d", dut.pc, dut.state);
    chk("halt.pc", {24'b0, dut.pc}, 32'd3);
    chk("halt.state", {29'b0, dut.state}, 32'd4);
    chk("halt.halted", {31'b0, dut.halted}, 32'd1);

    // PC wrap: branch backwards past 0 to 254, then 255 -> 0 wraps on fetch.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 256; k++) dut.ram.memory[k] <= 32'h0;
    dut.ram.memory[0]   <= enc(4'h8, 4'd0, 4'd0, 4'd0, 16'hFFFD);
    dut.ram.memory[1]   <= enc(4'hF, 4'd0, 4'd0, 4'd0, 16'd0);
    dut.ram.memory[254] <= enc(4'h1, 4'd8, 4'd0, 4'd0, 16'd3);
    dut.ram.memory[255] <= enc(4'h8, 4'd0, 4'd0, 4'd0, 16'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_until_halt(300, cyc);
    $display("pc wrap: cycles=%0d pc=%0d r8=%h", cyc, dut.pc, dut.regs[8]);
    chk("wrap.r8", dut.regs[8], 32'd3);
    chk("wrap.pc", {24'b0, dut.pc}, 32'd2);
    chk("wrap.cycles", cyc, 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
